calculator_top: RTL and testbench

CALCULATOR_TOP -- requirements
Module: calculator_top

---
 rtl/calculator_pkg.sv | 62 ++++++
 rtl/calculator_top_keypad_scanner.sv | 71 +++++++
 rtl/calculator_top.sv | 104 ++++++++++
 tb/tb_calculator_top.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// calculator_pkg: shared types, key codes and helpers for the keypad calculator
package calculator_pkg;

   typedef enum logic [1:0] {
      ST_ENTER_A,
      ST_ENTER_B,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL
   } op_t;

   typedef enum logic [1:0] {
      SC_IDLE,
      SC_DEB,
      SC_HELD,
      SC_REL
   } scan_t;

   localparam logic [3:0] KEY_ADD  = 4'd3;
   localparam logic [3:0] KEY_SUB  = 4'd7;
   localparam logic [3:0] KEY_MUL  = 4'd11;
   localparam logic [3:0] KEY_EQ   = 4'd12;
   localparam logic [3:0] KEY_ZERO = 4'd13;
   localparam logic [3:0] KEY_CLR  = 4'd14;
   localparam logic [3:0] KEY_NEG  = 4'd15;

   localparam logic [19:0] MAG_MAX = 20'd32767;

   // Digit keys occupy columns 0-2 of rows 0-2, plus the zero key.
   function automatic logic is_digit(input logic [3:0] k);
      return ((k[1:0] != 2'd3) && (k[3:2] != 2'd3)) || (k == KEY_ZERO);
   endfunction

   // Decimal value of a digit key; rows 0-2 hold 1-3, 4-6, 7-9.
   function automatic logic [3:0] digit_val(input logic [3:0] k);
      return (k == KEY_ZERO) ? 4'd0 :
             (k < 4'd4)      ? k + 4'd1 :
             (k < 4'd8)      ? k :
                               k - 4'd1;
   endfunction

   function automatic op_t key_op(input logic [3:0] k);
      return (k == KEY_ADD) ? OP_ADD : (k == KEY_SUB) ? OP_SUB : OP_MUL;
   endfunction

   // Two's-complement value of a sign/magnitude operand.
   function automatic logic [15:0] signed_val(input logic neg, input logic [15:0] mag);
      return neg ? (~mag + 16'd1) : mag;
   endfunction

   // Wrapping 16-bit arithmetic; the low half of a product is sign-agnostic.
   function automatic logic [15:0] alu(input op_t op, input logic [15:0] a, input logic [15:0] b);
      return (op == OP_ADD) ? a + b :
             (op == OP_SUB) ? a - b :
                              a * b;
   endfunction

endpackage

// File: rtl/calculator_top_keypad_scanner.sv
// keypad_scanner: column scan, two-sample debounce and release detection for a 4x4 keypad
module keypad_scanner
   import calculator_pkg::*;
(
   input  logic       clk,
   input  logic       nRST,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic       o_evt,
   output logic [3:0] o_key
);

   scan_t       r_st;
   logic [1:0]  r_col;
   logic [3:0]  r_row;
   logic        r_evt;
   logic [3:0]  r_key;
   logic        w_idle;
   logic [1:0]  w_row_idx;

   assign w_idle = (i_row == 4'hF);
   assign o_col  = ~(4'b0001 << r_col);
   assign o_evt  = r_evt;
   assign o_key  = r_key;

   // Lowest-numbered low row wins when several rows are pulled down.
   always_comb begin
      w_row_idx = !i_row[0] ? 2'd0 : !i_row[1] ? 2'd1 : !i_row[2] ? 2'd2 : 2'd3;
   end

   // Scan until a row goes low, require two equal samples, fire once, then wait for two idle samples.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_st  <= SC_IDLE;
         r_col <= 2'd0;
         r_row <= 4'hF;
         r_evt <= 1'b0;
         r_key <= 4'd0;
      end else begin
         r_evt <= 1'b0;
         case (r_st)
            SC_IDLE: begin
               if (w_idle) r_col <= r_col + 2'd1;
               else begin
                  r_row <= i_row;
                  r_st  <= SC_DEB;
               end
            end
            SC_DEB: begin
               if (i_row == r_row) begin
                  r_evt <= 1'b1;
                  r_key <= {w_row_idx, r_col};
                  r_st  <= SC_HELD;
               end else if (w_idle) r_st <= SC_IDLE;
               else r_row <= i_row;
            end
            SC_HELD: begin
               if (w_idle) r_st <= SC_REL;
            end
            SC_REL: begin
               if (w_idle) begin
                  r_st  <= SC_IDLE;
                  r_col <= r_col + 2'd1;
               end else r_st <= SC_HELD;
            end
            default: r_st <= SC_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/calculator_top.sv
// calculator_top: keypad-driven 16-bit signed calculator with add/sub/mul
module calculator_top
   import calculator_pkg::*;
(
   input  logic        clk,
   input  logic        nRST,
   input  logic [3:0]  RowIn,
   output logic [3:0]  ColOut,
   output logic [15:0] display_output,
   output logic        complete
);

   state_t      r_state;
   op_t         r_op;
   logic [15:0] r_a;
   logic [15:0] r_mag;
   logic        r_neg;
   logic [15:0] r_disp;
   logic        r_done;

   logic        w_evt;
   logic [3:0]  w_key;
   state_t      w_st;
   op_t         w_op;
   logic [15:0] w_a;
   logic [15:0] w_mag;
   logic        w_neg;
   logic [15:0] w_disp;
   logic        w_done;
   logic [19:0] w_ext;

   keypad_scanner u_scan (
      .clk   (clk),
      .nRST  (nRST),
      .i_row (RowIn),
      .o_col (ColOut),
      .o_evt (w_evt),
      .o_key (w_key)
   );

   assign display_output = r_disp;
   assign complete       = r_done;

   // Next state for a key event; a key in DONE first wipes the old calculation and acts as in ENTER_A.
   always_comb begin
      w_st   = (r_state == ST_DONE) ? ST_ENTER_A : r_state;
      w_op   = (r_state == ST_DONE) ? OP_ADD : r_op;
      w_a    = (r_state == ST_DONE) ? 16'd0 : r_a;
      w_mag  = (r_state == ST_DONE) ? 16'd0 : r_mag;
      w_neg  = (r_state == ST_DONE) ? 1'b0 : r_neg;
      w_disp = r_disp;
      w_done = 1'b0;
      w_ext  = {4'd0, w_mag} * 20'd10 + {16'd0, digit_val(w_key)};
      if (w_key == KEY_CLR) begin
         w_st   = ST_ENTER_A;
         w_op   = OP_ADD;
         w_a    = 16'd0;
         w_mag  = 16'd0;
         w_neg  = 1'b0;
         w_disp = 16'd0;
      end else if (is_digit(w_key)) begin
         if (w_ext <= MAG_MAX) w_mag = w_ext[15:0];
         w_disp = signed_val(w_neg, w_mag);
      end else if (w_key == KEY_NEG) begin
         w_neg  = ~w_neg;
         w_disp = signed_val(w_neg, w_mag);
      end else if (w_key == KEY_EQ) begin
         w_disp = (w_st == ST_ENTER_A) ? signed_val(w_neg, w_mag) : alu(w_op, w_a, signed_val(w_neg, w_mag));
         w_done = 1'b1;
         w_st   = ST_DONE;
      end else begin
         w_op = key_op(w_key);
         if (w_st == ST_ENTER_A) begin
            w_a    = signed_val(w_neg, w_mag);
            w_mag  = 16'd0;
            w_neg  = 1'b0;
            w_disp = 16'd0;
            w_st   = ST_ENTER_B;
         end
      end
   end

   // Commit the decoded update on the clock after the scanner issues its event.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_state <= ST_ENTER_A;
         r_op    <= OP_ADD;
         r_a     <= 16'd0;
         r_mag   <= 16'd0;
         r_neg   <= 1'b0;
         r_disp  <= 16'd0;
         r_done  <= 1'b0;
      end else if (w_evt) begin
         r_state <= w_st;
         r_op    <= w_op;
         r_a     <= w_a;
         r_mag   <= w_mag;
         r_neg   <= w_neg;
         r_disp  <= w_disp;
         r_done  <= w_done;
      end
   end

endmodule

// File: tb/tb_calculator_top.sv
// tb_calculator_top: directed keypad sequences against hand-computed calculator results
module tb_calculator_top;

   logic        clk;
   logic        nRST;
   logic [3:0]  RowIn;
   logic [3:0]  ColOut;
   logic [15:0] display_output;
   logic        complete;

   logic        pressed;
   logic [1:0]  p_row;
   logic [1:0]  p_col;
   logic [3:0]  exp_col;
   int          checks;
   int          errors;

   localparam logic [3:0] K_ADD = 4'd3, K_SUB = 4'd7, K_MUL = 4'd11, K_EQ = 4'd12;
   localparam logic [3:0] K_CLR = 4'd14, K_NEG = 4'd15;

   calculator_top dut (
      .clk            (clk),
      .nRST           (nRST),
      .RowIn          (RowIn),
      .ColOut         (ColOut),
      .display_output (display_output),
      .complete       (complete)
   );

   assign RowIn = (pressed && ColOut == ~(4'b0001 << p_col)) ? ~(4'b0001 << p_row) : 4'hF;

   always #5 clk = ~clk;

   function automatic logic [3:0] dkey(input int d);
      return (d == 0) ? 4'd13 : (d <= 3) ? 4'(d - 1) : (d <= 6) ? 4'(d) : 4'(d + 1);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      p_row   = k[3:2];
      p_col   = k[1:0];
      pressed = 1'b1;
      repeat (10) @(negedge clk);
      pressed = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic num(input int d);
      press(dkey(d));
   endtask

   initial begin
      clk = 1'b0; nRST = 1'b0; pressed = 1'b0; p_row = 2'd0; p_col = 2'd0;
      checks = 0; errors = 0;
      #1;
      chk("reset_col", {12'd0, ColOut}, 16'h000E);
      chk("reset_disp", display_output, 16'h0000);
      chk("reset_complete", {15'd0, complete}, 16'h0000);
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      exp_col = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_col = {exp_col[2:0], exp_col[3]};
         chk("idle_rotate", {12'd0, ColOut}, {12'd0, exp_col});
      end
      press(K_NEG); num(3);
      chk("neg3_disp", display_output, 16'hFFFD);
      press(K_MUL); press(K_NEG); num(4);
      chk("negb4_disp", display_output, 16'hFFFC);
      press(K_EQ);
      chk("negmul_disp", display_output, 16'd12);
      chk("negmul_complete", {15'd0, complete}, 16'd1);
      num(3);
      chk("newcalc_disp", display_output, 16'd3);
      chk("newcalc_complete", {15'd0, complete}, 16'd0);
      press(K_MUL); num(4); press(K_EQ);
      chk("mul_again", display_output, 16'd12);
      num(3); press(K_ADD); num(4); press(K_EQ);
      chk("add_3_4", display_output, 16'd7);
      num(5); press(K_SUB); num(4); press(K_EQ);
      chk("sub_5_4", display_output, 16'd1);
      press(K_NEG); num(5); press(K_SUB); num(4); press(K_EQ);
      chk("sub_neg", display_output, 16'hFFF7);
      for (int i = 0; i < 5; i++) num(9);
      chk("mag_9999", display_output, 16'd9999);
      press(K_MUL);
      for (int i = 0; i < 5; i++) num(9);
      press(K_EQ);
      chk("mul_wrap", display_output, 16'h92E1);
      num(3); num(2); num(7); num(6); num(7); num(8);
      chk("mag_max", display_output, 16'h7FFF);
      press(K_ADD); num(1); press(K_EQ);
      chk("add_wrap", display_output, 16'h8000);
      num(6); press(K_ADD); press(K_SUB); num(2); press(K_EQ);
      chk("op_replace", display_output, 16'd4);
      press(K_CLR); num(4); num(2); press(K_EQ);
      chk("eq_in_a", display_output, 16'd42);
      chk("eq_in_a_complete", {15'd0, complete}, 16'd1);
      num(4); num(0); num(0); num(0); num(0);
      chk("five_digits", display_output, 16'd4000);
      press(K_CLR);
      chk("clr_disp", display_output, 16'd0);
      chk("clr_complete", {15'd0, complete}, 16'd0);
      p_row = 2'd1; p_col = 2'd1; pressed = 1'b1;
      repeat (50) @(negedge clk);
      chk("hold_col", {12'd0, ColOut}, 16'h000D);
      chk("hold_once", display_output, 16'd5);
      pressed = 1'b0;
      @(negedge clk);
      chk("release_frozen", {12'd0, ColOut}, 16'h000D);
      @(negedge clk);
      chk("release_resume", {12'd0, ColOut}, 16'h000B);
      repeat (3) @(negedge clk);
      press(K_EQ);
      chk("pre_reset_complete", {15'd0, complete}, 16'd1);
      p_row = 2'd2; p_col = 2'd0; pressed = 1'b1;
      @(negedge clk);
      nRST = 1'b0;
      #1;
      chk("async_col", {12'd0, ColOut}, 16'h000E);
      chk("async_disp", display_output, 16'd0);
      chk("async_complete", {15'd0, complete}, 16'd0);
      repeat (2) @(negedge clk);
      nRST = 1'b1;
      repeat (12) @(negedge clk);
      pressed = 1'b0;
      repeat (4) @(negedge clk);
      chk("redebounce", display_output, 16'd7);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
